// File: rtl/rom_port_arbiter_if.sv
// Signal bundle between the two ROM masters (CPU fetch, debug/loader), the arbiter and the ROM.
// The arbiter uses the slave modport; the master modport is the requester/ROM side.
interface rom_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              m0_req;
  logic [ADDR_W-1:0] m0_addr;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic [ADDR_W-1:0] m1_addr;
  logic              m1_lock;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;

  logic              rom_ce;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;

  modport slave (
    input  m0_req, m0_addr, m1_req, m1_addr, m1_lock, rom_data,
    output m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata, rom_ce, rom_addr
  );

  modport master (
    output m0_req, m0_addr, m1_req, m1_addr, m1_lock, rom_data,
    input  m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata, rom_ce, rom_addr
  );
endinterface

// File: rtl/rom_port_arbiter.sv
// Round-robin arbiter sharing one combinational ROM between CPU fetch (m0) and debug port (m1),
// with a bounded burst lock for m1 and a one-cycle registered read response.
module rom_port_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  rom_port_arbiter_if.slave    bus
);
  localparam int unsigned CntW = $clog2(MAX_LOCK + 1);

  typedef enum logic [0:0] {StArb, StLock1} mode_e;

  mode_e             state_q, state_d;
  logic [CntW-1:0]   lock_cnt_q, lock_cnt_d;
  logic              rr_last_q, rr_last_d;
  logic              rsp_valid_q, rsp_sel_q;
  logic [DATA_W-1:0] rsp_data_q;

  logic gnt0, gnt1, arb_en, pref_m0;
  logic gnt0_o, gnt1_o;

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    rr_last_d  = rr_last_q;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    arb_en     = 1'b0;
    pref_m0    = rr_last_q;

    unique case (state_q)
      StArb: arb_en = 1'b1;
      StLock1: begin
        if (bus.m1_req && bus.m1_lock && (lock_cnt_q < CntW'(MAX_LOCK))) begin
          gnt1       = 1'b1;
          lock_cnt_d = lock_cnt_q + CntW'(1);
        end else begin
          // Burst over: arbitrate this same cycle with m0 preferred, so no bubble.
          state_d    = StArb;
          lock_cnt_d = '0;
          rr_last_d  = 1'b1;
          arb_en     = 1'b1;
          pref_m0    = 1'b1;
        end
      end
      default: state_d = StArb;
    endcase

    if (arb_en) begin
      gnt0 = bus.m0_req && (!bus.m1_req || pref_m0);
      gnt1 = bus.m1_req && !gnt0;
      if (gnt1 && bus.m1_lock) begin
        state_d    = StLock1;
        lock_cnt_d = CntW'(1);
      end
    end

    if (gnt0) rr_last_d = 1'b0;
    if (gnt1) rr_last_d = 1'b1;
  end

  // Outputs are forced low while reset is held, even with requests pending.
  assign gnt0_o       = gnt0 & rst_ni;
  assign gnt1_o       = gnt1 & rst_ni;
  assign bus.m0_gnt   = gnt0_o;
  assign bus.m1_gnt   = gnt1_o;
  assign bus.rom_ce   = gnt0_o | gnt1_o;
  assign bus.rom_addr = gnt1_o ? bus.m1_addr : (gnt0_o ? bus.m0_addr : '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StArb;
      lock_cnt_q  <= '0;
      rr_last_q   <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_sel_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      rr_last_q   <= rr_last_d;
      rsp_valid_q <= gnt0 | gnt1;
      if (gnt0 | gnt1) begin
        rsp_sel_q  <= gnt1;
        rsp_data_q <= bus.rom_data;
      end
    end
  end

  assign bus.m0_rvalid = rsp_valid_q & ~rsp_sel_q;
  assign bus.m1_rvalid = rsp_valid_q & rsp_sel_q;
  assign bus.m0_rdata  = rsp_sel_q ? '0 : rsp_data_q;
  assign bus.m1_rdata  = rsp_sel_q ? rsp_data_q : '0;
endmodule

// File: tb/tb_rom_port_arbiter.sv
// Scenario bench for rom_port_arbiter: grants checked inline, read responses via a scoreboard.
module tb_rom_port_arbiter;
  localparam int MaxLock = 8;

  typedef struct {
    bit          m1;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  exp_t sb[$];
  exp_t e;
  logic [31:0] w0, w1;

  rom_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  rom_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LOCK(MaxLock)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  assign bus.rom_data = rom_word(bus.rom_addr);

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Response scoreboard: sampled 2 time units after each rising edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #2;
    n_checks++;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e  = sb.pop_front();
      w0 = e.m1 ? 32'h0 : e.data;
      w1 = e.m1 ? e.data : 32'h0;
      if ({bus.m0_rvalid, bus.m1_rvalid, bus.m0_rdata, bus.m1_rdata} !==
          {!e.m1, e.m1, w0, w1}) begin
        n_fail++;
        $display("FAIL response@%0d: got rv=%b%b d0=%h d1=%h want rv=%b%b d0=%h d1=%h", cyc,
                 bus.m0_rvalid, bus.m1_rvalid, bus.m0_rdata, bus.m1_rdata, !e.m1, e.m1, w0, w1);
      end
    end else if ({bus.m0_rvalid, bus.m1_rvalid} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_rvalid@%0d: got rv=%b%b want 00", cyc, bus.m0_rvalid, bus.m1_rvalid);
    end
  end

  task automatic drive(input bit r0, input logic [31:0] a0, input bit r1, input logic [31:0] a1,
                       input bit lk);
    bus.m0_req  = r0;
    bus.m0_addr = a0;
    bus.m1_req  = r1;
    bus.m1_addr = a1;
    bus.m1_lock = lk;
  endtask

  task automatic expect_rsp(input bit m1, input logic [31:0] a);
    sb.push_back('{m1: m1, data: rom_word(a), due: cyc + 1});
  endtask

  task automatic apply_reset();
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    drive(1, 32'h40, 1, 32'h80, 0);
    repeat (3) begin
      #1;
      n_checks++;
      if ({bus.m0_gnt, bus.m1_gnt, bus.rom_ce, bus.rom_addr, bus.m0_rvalid, bus.m1_rvalid,
           bus.m0_rdata, bus.m1_rdata} !== {3'b000, 32'h0, 2'b00, 64'h0}) begin
        n_fail++;
        $display("FAIL reset_outputs: got gnt=%b%b ce=%b addr=%h rv=%b%b want all zero",
                 bus.m0_gnt, bus.m1_gnt, bus.rom_ce, bus.rom_addr, bus.m0_rvalid, bus.m1_rvalid);
      end
      @(negedge clk);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if ({bus.m0_gnt, bus.m1_gnt, bus.rom_ce, bus.rom_addr} !==
          {i == 0, i == 1, 1'b1, (i == 0) ? 32'h40 : 32'h80}) begin
        n_fail++;
        $display("FAIL reset_release[%0d]: got gnt=%b%b ce=%b addr=%h", i, bus.m0_gnt,
                 bus.m1_gnt, bus.rom_ce, bus.rom_addr);
      end
      expect_rsp(i == 1, (i == 0) ? 32'h40 : 32'h80);
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_stream();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1, 32'(4 * i), 0, 32'h100, 0);
      #1;
      n_checks++;
      if ({bus.m0_gnt, bus.m1_gnt, bus.rom_ce, bus.rom_addr} !== {3'b101, 32'(4 * i)}) begin
        n_fail++;
        $display("FAIL stream[%0d]: got gnt=%b%b ce=%b addr=%h want 10 1 %h", i, bus.m0_gnt,
                 bus.m1_gnt, bus.rom_ce, bus.rom_addr, 32'(4 * i));
      end
      expect_rsp(0, 32'(4 * i));
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(0, 32'h8, 0, 32'h100, 1);
      #1;
      n_checks++;
      if ({bus.m0_gnt, bus.m1_gnt, bus.rom_ce, bus.rom_addr} !== {3'b000, 32'h0}) begin
        n_fail++;
        $display("FAIL stream_idle[%0d]: got gnt=%b%b ce=%b addr=%h want 00 0 0", i,
                 bus.m0_gnt, bus.m1_gnt, bus.rom_ce, bus.rom_addr);
      end
    end
  endtask

  task automatic test_contention();
    logic [31:0] a;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(1, 32'h10, 1, 32'h20, 0);
      a = (i % 2 == 0) ? 32'h10 : 32'h20;
      #1;
      n_checks++;
      if ({bus.m0_gnt, bus.m1_gnt, bus.rom_addr} !== {i % 2 == 0, i % 2 == 1, a}) begin
        n_fail++;
        $display("FAIL contention[%0d]: got gnt=%b%b addr=%h want %b%b %h", i, bus.m0_gnt,
                 bus.m1_gnt, bus.rom_addr, i % 2 == 0, i % 2 == 1, a);
      end
      expect_rsp(i % 2 == 1, a);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_burst_lock();
    bit m1w;
    apply_reset();
    @(negedge clk);
    drive(1, 32'h30, 0, 32'h50, 0);
    expect_rsp(0, 32'h30);
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      drive(1, 32'h30, 1, 32'h50 + 32'(4 * j), 1);
      m1w = (j != MaxLock);
      #1;
      n_checks++;
      if ({bus.m0_gnt, bus.m1_gnt} !== {!m1w, m1w}) begin
        n_fail++;
        $display("FAIL burst_lock[%0d]: got gnt=%b%b want %b%b", j, bus.m0_gnt, bus.m1_gnt,
                 !m1w, m1w);
      end
      expect_rsp(m1w, m1w ? 32'h50 + 32'(4 * j) : 32'h30);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_lock_release();
    bit m1w;
    apply_reset();
    @(negedge clk);
    drive(1, 32'h60, 0, 32'h70, 0);
    expect_rsp(0, 32'h60);
    // 3 locked m1 grants, release with m0 waiting, then a fresh full-length burst.
    for (int j = 0; j < 13; j++) begin
      @(negedge clk);
      drive(1, 32'h60, 1, 32'h70, j != 3);
      m1w = !(j == 3 || j == 12);
      #1;
      n_checks++;
      if ({bus.m0_gnt, bus.m1_gnt} !== {!m1w, m1w}) begin
        n_fail++;
        $display("FAIL lock_release[%0d]: got gnt=%b%b want %b%b", j, bus.m0_gnt, bus.m1_gnt,
                 !m1w, m1w);
      end
      expect_rsp(m1w, m1w ? 32'h70 : 32'h60);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_async_reset();
    apply_reset();
    @(negedge clk);
    drive(1, 32'h90, 0, 32'hA0, 0);
    expect_rsp(0, 32'h90);
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      drive(1, 32'h90, 1, 32'hA0, 1);
      #1;
      n_checks++;
      if ({bus.m0_gnt, bus.m1_gnt} !== 2'b01) begin
        n_fail++;
        $display("FAIL async_pre[%0d]: got gnt=%b%b want 01", j, bus.m0_gnt, bus.m1_gnt);
      end
      expect_rsp(1, 32'hA0);
    end
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    n_checks++;
    if ({bus.m0_gnt, bus.m1_gnt, bus.rom_ce, bus.rom_addr, bus.m0_rvalid, bus.m1_rvalid,
         bus.m0_rdata, bus.m1_rdata} !== {3'b000, 32'h0, 2'b00, 64'h0}) begin
      n_fail++;
      $display("FAIL async_reset: got gnt=%b%b ce=%b addr=%h rv=%b%b d1=%h want all zero",
               bus.m0_gnt, bus.m1_gnt, bus.rom_ce, bus.rom_addr, bus.m0_rvalid, bus.m1_rvalid,
               bus.m1_rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 2; j++) begin
      #1;
      n_checks++;
      if ({bus.m0_gnt, bus.m1_gnt} !== {j == 0, j == 1}) begin
        n_fail++;
        $display("FAIL async_restart[%0d]: got gnt=%b%b want %b%b", j, bus.m0_gnt, bus.m1_gnt,
                 j == 0, j == 1);
      end
      expect_rsp(j == 1, (j == 0) ? 32'h90 : 32'hA0);
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0);
    test_reset();
    test_stream();
    test_contention();
    test_burst_lock();
    test_lock_release();
    test_async_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rom_port_arbiter.md
# rom_port_arbiter

Two-master arbiter that shares the single combinational instruction ROM between the CPU fetch port (master 0) and a debug/loader read port (master 1). It sits between the CPU and the ROM in the SOPC top level. Each cycle it grants at most one master, drives the ROM enable and address, and registers the returned word for delivery one cycle later. Arbitration is round-robin, with an optional bounded burst lock for master 1.

## Interface
- ADDR_W, 32, ROM address width
- DATA_W, 32, instruction word width
- MAX_LOCK, 8, maximum consecutive master-1 grants while m1_lock is held (≥1)

- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset; asynchronous and active-low
- m0_req  in  1  CPU fetch request; held with m0_addr stable until m0_gnt
- m0_addr  in  ADDR_W  CPU fetch address
- m0_gnt  out  1  combinational: request accepted this cycle
- m0_rvalid  out  1  registered: m0_rdata valid (1-cycle pulse per grant)
- m0_rdata  out  DATA_W  registered read data for master 0
- m1_req, m1_addr, m1_gnt, m1_rvalid, m1_rdata  same as master 0, for the debug port
- m1_lock  in  1  master 1 requests back-to-back grants (burst)
- rom_ce  out  1  ROM enable, high only in a granted cycle
- rom_addr  out  ADDR_W  address of the granted master, 0 when idle
- rom_data  in  DATA_W  ROM read word (combinational from rom_addr)

## Operation
- State: rr_last (last granted master), lock_cnt (0..MAX_LOCK), rsp_sel, rsp_valid, rsp_data.
- FSM over grant mode:
  - ARB: normal round-robin.
  - LOCK1: master 1 burst in progress.
- ARB mode:
  - Only one requester: that master is granted.
  - Both requesting: the master ≠ rr_last is granted.
  - A grant of m1 with m1_lock=1 enters LOCK1 with lock_cnt=1.
- LOCK1 mode:
  - m1_req=1, m1_lock=1 and lock_cnt<MAX_LOCK: m1 is granted regardless of m0, and lock_cnt increments.
  - m1_lock=0, m1_req=0, or lock_cnt==MAX_LOCK: return to ARB with lock_cnt=0 and rr_last=1, so a waiting m0 wins the next cycle.
- Granted cycle:
  - rom_ce=1 and rom_addr = winner's address.
  - rom_data is captured into the response register at the clock edge.
  - The winner's rvalid is asserted the following cycle, and rr_last is updated.
- Non-granted cycles:
  - rom_ce=0, rom_addr=0, and both gnt outputs are 0.
  - The response register holds its data; rvalid outputs drop to 0.
- rdata of the non-selected master is 0, never stale data of the other master.
- No request queueing: an un-granted master keeps req high and retries. The arbiter never drops an asserted request.

## Timing
- Reset (rst=0, asynchronous): every output is 0; rr_last=1 (m0 preferred first); mode=ARB; lock_cnt=0; response registers cleared.
- Deassertion of rst is synchronised by the top level. The first grant can occur in the first clock edge after release.
- Latency:
  - gnt is in the same cycle as req (combinational).
  - rvalid/rdata is exactly 1 cycle after gnt.
  - Throughput is 1 access per cycle total.
- Back-to-back grants to alternating masters produce alternating rvalid pulses with no bubble.
- Fairness bounds:
  - With both masters continuously requesting and no lock, grants strictly alternate.
  - Under lock, m0 waits at most MAX_LOCK cycles.
- Reset asserted mid-access: a pending rvalid is lost, and state returns to reset values immediately.
- m1_lock with m1_req=0 has no effect. m1_lock changes take effect in the same cycle's arbitration.

## Test plan
- Reset: hold rst=0 with both reqs high -> all outputs 0, no rom_ce. Release -> first grant goes to m0, with m0_rvalid the next cycle carrying ROM[m0_addr].
- Single master streaming: m0_req=1, addresses 0x0,0x4,0x8 on successive cycles -> m0_gnt=1 every cycle; m0_rdata = ROM words one cycle later; m1 outputs stay 0.
- Contention: both req=1 for 6 cycles, m0_addr=0x10, m1_addr=0x20 -> grants alternate m0,m1,m0,…; each rvalid/rdata routes to the correct master; rom_addr alternates 0x10/0x20.
- Burst lock: MAX_LOCK=8, m1_req=m1_lock=1 and m0_req=1 for 12 cycles -> m1 granted 8 consecutive cycles, then m0 is granted, then m1 resumes with a fresh lock.
- Lock release: m1_lock dropped after 3 locked grants while m0 waits -> m0 granted the next cycle; lock_cnt back to 0.
- Async reset mid-burst: assert rst=0 between clock edges during LOCK1 -> outputs 0 immediately without a clock edge; after release, arbitration restarts preferring m0.
